// File: rtl/fetch_pkg.sv
// Shared types and widths for the fetch-to-decode instruction buffer.
package fetch_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned INST_W    = 32;
  localparam int unsigned BP_TYPE_W = 4;

  // Branch-predict pack carried alongside a single instruction
  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      target;
    logic [BP_TYPE_W-1:0] btype;
    logic                 taken;
  } bp_pack_t;

  // One buffered instruction
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
    bp_pack_t          bp;
  } fetch_entry_t;

  // Index width that stays legal when there is only one slot
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_inst_buffer_compact.sv
// Per-slot compaction for an incoming fetch packet: write offsets from a
// prefix popcount of the slot valids, the total written count, and the
// fully formed entry (pc, instruction, predict pack) for every slot.
module fetch_slot_compact
  import fetch_pkg::*;
#(
  parameter  int unsigned FETCH_W = 2,
  localparam int unsigned SelW    = sel_width(FETCH_W),
  localparam int unsigned OffW    = $clog2(FETCH_W + 1)
) (
  input  logic [FETCH_W-1:0]           valids,
  input  logic [XLEN-1:0]              pc,
  input  logic [INST_W*FETCH_W-1:0]    insts,
  input  logic                         bp_valid,
  input  logic [XLEN-1:0]              bp_target,
  input  logic [BP_TYPE_W-1:0]         bp_type,
  input  logic [SelW-1:0]              bp_select,
  input  logic                         bp_taken,
  output logic [FETCH_W-1:0][OffW-1:0] offset,
  output logic [OffW-1:0]              n,
  output fetch_entry_t [FETCH_W-1:0]   entries
);

  // Prefix popcount: each valid slot lands right after the valid slots below it
  always_comb begin
    logic [OffW-1:0] acc;
    acc = '0;
    for (int s = 0; s < FETCH_W; s++) begin
      offset[s] = acc;
      acc       = acc + OffW'(valids[s]);
    end
    n = acc;
  end

  // Build each slot's entry; the predict pack only sticks to its own valid slot
  always_comb begin
    for (int s = 0; s < FETCH_W; s++) begin
      logic attach;
      attach                = bp_valid & valids[s] & (bp_select == SelW'(s));
      entries[s].pc         = pc + XLEN'(4 * s);
      entries[s].inst       = insts[s*INST_W +: INST_W];
      entries[s].bp.valid   = attach;
      entries[s].bp.taken   = attach & bp_taken;
      entries[s].bp.target  = attach ? bp_target : '0;
      entries[s].bp.btype   = attach ? bp_type : '0;
    end
  end

endmodule

// File: rtl/fetch_inst_buffer.sv
// Fetch-to-decode instruction buffer: compacts valid fetch slots into a
// circular queue of single instructions and presents the oldest DECODE_W
// entries to decode. Flush empties the queue on the next edge.
module fetch_inst_buffer #(
  parameter  int unsigned DEPTH    = 16,
  parameter  int unsigned FETCH_W  = 2,
  parameter  int unsigned DECODE_W = 2,
  parameter  int unsigned XLEN     = 64,
  localparam int unsigned SelW     = (FETCH_W > 1) ? $clog2(FETCH_W) : 1,
  localparam int unsigned CntW     = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [FETCH_W-1:0]     io_in_bits_valids,
  input  logic [XLEN-1:0]        io_in_bits_pc,
  input  logic [32*FETCH_W-1:0]  io_in_bits_insts,
  input  logic                   io_in_bits_bp_valid,
  input  logic [XLEN-1:0]        io_in_bits_bp_target,
  input  logic [3:0]             io_in_bits_bp_type,
  input  logic [SelW-1:0]        io_in_bits_bp_select,
  input  logic                   io_in_bits_bp_taken,
  input  logic                   io_out_ready,
  output logic [DECODE_W-1:0]    io_out_valid,
  output logic [XLEN*DECODE_W-1:0] io_out_pc,
  output logic [32*DECODE_W-1:0] io_out_inst,
  output logic [DECODE_W-1:0]    io_out_bp_valid,
  output logic [DECODE_W-1:0]    io_out_bp_taken,
  output logic [XLEN*DECODE_W-1:0] io_out_bp_target,
  output logic [4*DECODE_W-1:0]  io_out_bp_type,
  output logic [CntW-1:0]        io_count,
  output logic                   io_full,
  input  logic                   io_i_flush
);

  import fetch_pkg::fetch_entry_t;

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OffW = $clog2(FETCH_W + 1);

  fetch_entry_t mem_q [DEPTH];

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] deq_n;
  logic            in_ready, fire_in, fire_out;

  logic [FETCH_W-1:0][OffW-1:0] offset;
  logic [OffW-1:0]              enq_n;
  fetch_entry_t [FETCH_W-1:0]   slot_entries;
  fetch_entry_t [DECODE_W-1:0]  lane;

  fetch_slot_compact #(
    .FETCH_W(FETCH_W)
  ) u_compact (
    .valids    (io_in_bits_valids),
    .pc        (io_in_bits_pc),
    .insts     (io_in_bits_insts),
    .bp_valid  (io_in_bits_bp_valid),
    .bp_target (io_in_bits_bp_target),
    .bp_type   (io_in_bits_bp_type),
    .bp_select (io_in_bits_bp_select),
    .bp_taken  (io_in_bits_bp_taken),
    .offset    (offset),
    .n         (enq_n),
    .entries   (slot_entries)
  );

  // Room for a whole packet, from registered count only so dequeue never aliases a write
  always_comb begin
    in_ready = (CntW'(DEPTH) - count_q) >= CntW'(FETCH_W);
    fire_in  = io_in_valid & in_ready & ~io_i_flush;
    fire_out = io_out_ready & ~io_i_flush;
    deq_n    = (count_q >= CntW'(DECODE_W)) ? CntW'(DECODE_W) : count_q;
  end

  assign io_in_ready = in_ready;
  assign io_full     = ~in_ready;
  assign io_count    = count_q;

  // Pointer and occupancy next-state; flush overrides both fires
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (io_i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (fire_in)  tail_d = tail_q + PtrW'(enq_n);
      if (fire_out) head_d = head_q + PtrW'(deq_n);
      count_d = count_q + (fire_in ? CntW'(enq_n) : '0) - (fire_out ? deq_n : '0);
    end
  end

  // Control state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage; not reset, occupancy alone says what is live
  always_ff @(posedge clock) begin
    for (int s = 0; s < FETCH_W; s++) begin
      if (fire_in && io_in_bits_valids[s]) begin
        mem_q[tail_q + PtrW'(offset[s])] <= slot_entries[s];
      end
    end
  end

  // Read the oldest DECODE_W entries straight out of storage
  always_comb begin
    for (int i = 0; i < DECODE_W; i++) begin
      lane[i]                     = mem_q[head_q + PtrW'(i)];
      io_out_valid[i]             = (count_q > CntW'(i)) & ~io_i_flush;
      io_out_pc[i*XLEN +: XLEN]   = lane[i].pc;
      io_out_inst[i*32 +: 32]     = lane[i].inst;
      io_out_bp_valid[i]          = lane[i].bp.valid;
      io_out_bp_taken[i]          = lane[i].bp.taken;
      io_out_bp_target[i*XLEN +: XLEN] = lane[i].bp.target;
      io_out_bp_type[i*4 +: 4]    = lane[i].bp.btype;
    end
  end

endmodule

// File: tb/tb_fetch_inst_buffer.sv
// Randomized bench for fetch_inst_buffer against a queue-based reference model.
module tb_fetch_inst_buffer;

  localparam int DEPTH = 16;
  localparam int FW    = 2;
  localparam int DW    = 2;
  localparam int XL    = 64;

  logic            clock = 1'b0;
  logic            reset;
  logic            io_in_valid;
  logic            io_in_ready;
  logic [FW-1:0]   io_in_bits_valids;
  logic [XL-1:0]   io_in_bits_pc;
  logic [32*FW-1:0] io_in_bits_insts;
  logic            io_in_bits_bp_valid;
  logic [XL-1:0]   io_in_bits_bp_target;
  logic [3:0]      io_in_bits_bp_type;
  logic [0:0]      io_in_bits_bp_select;
  logic            io_in_bits_bp_taken;
  logic            io_out_ready;
  logic [DW-1:0]   io_out_valid;
  logic [XL*DW-1:0] io_out_pc;
  logic [32*DW-1:0] io_out_inst;
  logic [DW-1:0]   io_out_bp_valid;
  logic [DW-1:0]   io_out_bp_taken;
  logic [XL*DW-1:0] io_out_bp_target;
  logic [4*DW-1:0] io_out_bp_type;
  logic [4:0]      io_count;
  logic            io_full;
  logic            io_i_flush;

  always #5 clock = ~clock;

  fetch_inst_buffer dut (
    .clock                (clock),
    .reset                (reset),
    .io_in_valid          (io_in_valid),
    .io_in_ready          (io_in_ready),
    .io_in_bits_valids    (io_in_bits_valids),
    .io_in_bits_pc        (io_in_bits_pc),
    .io_in_bits_insts     (io_in_bits_insts),
    .io_in_bits_bp_valid  (io_in_bits_bp_valid),
    .io_in_bits_bp_target (io_in_bits_bp_target),
    .io_in_bits_bp_type   (io_in_bits_bp_type),
    .io_in_bits_bp_select (io_in_bits_bp_select),
    .io_in_bits_bp_taken  (io_in_bits_bp_taken),
    .io_out_ready         (io_out_ready),
    .io_out_valid         (io_out_valid),
    .io_out_pc            (io_out_pc),
    .io_out_inst          (io_out_inst),
    .io_out_bp_valid      (io_out_bp_valid),
    .io_out_bp_taken      (io_out_bp_taken),
    .io_out_bp_target     (io_out_bp_target),
    .io_out_bp_type       (io_out_bp_type),
    .io_count             (io_count),
    .io_full              (io_full),
    .io_i_flush           (io_i_flush)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        bpv;
    logic        tk;
    logic [63:0] tgt;
    logic [3:0]  typ;
  } ent_t;

  ent_t mq[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic set_idle();
    io_in_valid          = 1'b0;
    io_in_bits_valids    = '0;
    io_in_bits_pc        = '0;
    io_in_bits_insts     = '0;
    io_in_bits_bp_valid  = 1'b0;
    io_in_bits_bp_target = '0;
    io_in_bits_bp_type   = '0;
    io_in_bits_bp_select = '0;
    io_in_bits_bp_taken  = 1'b0;
    io_out_ready         = 1'b0;
    io_i_flush           = 1'b0;
  endtask

  task automatic drive_pkt(input logic [1:0] v, input logic [63:0] pc,
                           input logic [31:0] i0, input logic [31:0] i1);
    io_in_valid         = 1'b1;
    io_in_bits_valids   = v;
    io_in_bits_pc       = pc;
    io_in_bits_insts    = {i1, i0};
    io_in_bits_bp_valid = 1'b0;
  endtask

  // Advance one clock; reference model follows the queue rules with the current inputs
  task automatic tick();
    int  sz;
    bit  rdy;
    sz  = mq.size();
    rdy = (DEPTH - sz) >= FW;
    if (io_i_flush) begin
      mq.delete();
    end else begin
      if (io_out_ready) repeat ((sz < DW) ? sz : DW) void'(mq.pop_front());
      if (io_in_valid && rdy) begin
        for (int s = 0; s < FW; s++) begin
          if (io_in_bits_valids[s]) begin
            ent_t e;
            logic [63:0] ins;
            ins    = io_in_bits_insts >> (32 * s);
            e.pc   = io_in_bits_pc + 64'(4 * s);
            e.inst = ins[31:0];
            if (io_in_bits_bp_valid && int'(io_in_bits_bp_select) == s) begin
              e.bpv = 1'b1; e.tk = io_in_bits_bp_taken;
              e.tgt = io_in_bits_bp_target; e.typ = io_in_bits_bp_type;
            end else begin
              e.bpv = 1'b0; e.tk = 1'b0; e.tgt = '0; e.typ = '0;
            end
            mq.push_back(e);
          end
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic fill_to(input int target);
    for (int g = 0; g < 20 && mq.size() < target; g++) begin
      drive_pkt((target - mq.size() >= 2) ? 2'b11 : 2'b01,
                64'(32'h1000 + ($urandom_range(0, 255) << 3)), $urandom, $urandom);
      tick();
    end
    set_idle();
  endtask

  task automatic clear();
    set_idle();
    io_i_flush = 1'b1;
    tick();
    io_i_flush = 1'b0;
  endtask

  task automatic test_reset();
    n_run++; if (io_out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_out_valid got %b want 00", io_out_valid); end
    n_run++; if (io_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", io_in_ready); end
    n_run++; if (io_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", io_full); end
    n_run++; if (io_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", io_count); end
  endtask

  task automatic test_basic();
    drive_pkt(2'b11, 64'h8000_0000, 32'h0000_0013, 32'h0010_0093);
    tick();
    set_idle();
    n_run++; if (io_out_valid !== 2'b11) begin n_fail++; $display("FAIL basic_valid got %b want 11", io_out_valid); end
    n_run++; if (io_out_pc[63:0] !== 64'h8000_0000) begin n_fail++; $display("FAIL basic_pc0 got %h want 80000000", io_out_pc[63:0]); end
    n_run++; if (io_out_pc[127:64] !== 64'h8000_0004) begin n_fail++; $display("FAIL basic_pc1 got %h want 80000004", io_out_pc[127:64]); end
    n_run++; if (io_out_inst !== {32'h0010_0093, 32'h0000_0013}) begin n_fail++; $display("FAIL basic_inst got %h", io_out_inst); end
    n_run++; if (io_count !== 5'd2) begin n_fail++; $display("FAIL basic_count got %0d want 2", io_count); end
    clear();
  endtask

  task automatic test_bp_attach();
    drive_pkt(2'b10, 64'h100, 32'hdead_0001, 32'hbeef_0002);
    io_in_bits_bp_valid  = 1'b1;
    io_in_bits_bp_select = 1'b1;
    io_in_bits_bp_taken  = 1'b1;
    io_in_bits_bp_target = 64'h200;
    io_in_bits_bp_type   = 4'h3;
    tick();
    set_idle();
    n_run++; if (io_out_valid !== 2'b01) begin n_fail++; $display("FAIL bp_valid_lanes got %b want 01", io_out_valid); end
    n_run++; if (io_out_pc[63:0] !== 64'h104) begin n_fail++; $display("FAIL bp_pc got %h want 104", io_out_pc[63:0]); end
    n_run++; if (io_out_inst[31:0] !== 32'hbeef_0002) begin n_fail++; $display("FAIL bp_inst got %h want beef0002", io_out_inst[31:0]); end
    n_run++; if ({io_out_bp_valid[0], io_out_bp_taken[0]} !== 2'b11) begin n_fail++; $display("FAIL bp_bits got %b want 11", {io_out_bp_valid[0], io_out_bp_taken[0]}); end
    n_run++; if (io_out_bp_target[63:0] !== 64'h200 || io_out_bp_type[3:0] !== 4'h3) begin n_fail++; $display("FAIL bp_target got %h/%h want 200/3", io_out_bp_target[63:0], io_out_bp_type[3:0]); end
    n_run++; if (io_count !== 5'd1) begin n_fail++; $display("FAIL bp_count got %0d want 1", io_count); end
    clear();
  endtask

  task automatic test_full();
    logic [63:0] first_pc;
    fill_to(16);
    first_pc = mq[0].pc;
    n_run++; if (io_count !== 5'd16) begin n_fail++; $display("FAIL full_count got %0d want 16", io_count); end
    n_run++; if (io_full !== 1'b1 || io_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_flags got full=%b ready=%b want 1/0", io_full, io_in_ready); end
    drive_pkt(2'b11, 64'h9999_0000, 32'h1, 32'h2);
    tick();
    set_idle();
    n_run++; if (io_count !== 5'd16) begin n_fail++; $display("FAIL full_held got %0d want 16", io_count); end
    n_run++; if (io_out_pc[63:0] !== first_pc) begin n_fail++; $display("FAIL full_head got %h want %h", io_out_pc[63:0], first_pc); end
    io_out_ready = 1'b1;
    tick();
    set_idle();
    n_run++; if (io_count !== 5'd14 || io_in_ready !== 1'b1) begin n_fail++; $display("FAIL full_drain got count=%0d ready=%b want 14/1", io_count, io_in_ready); end
    clear();
  endtask

  task automatic test_back_to_back();
    fill_to(15);
    drive_pkt(2'b11, 64'h4000, 32'h11, 32'h22);
    io_out_ready = 1'b1;
    #1;
    n_run++; if (io_in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready15 got %b want 0", io_in_ready); end
    tick();
    set_idle();
    n_run++; if (io_count !== 5'(mq.size()) || mq.size() != 13) begin n_fail++; $display("FAIL b2b_count15 got %0d want 13", io_count); end
    fill_to(14);
    drive_pkt(2'b11, 64'h5000, 32'h33, 32'h44);
    io_out_ready = 1'b1;
    #1;
    n_run++; if (io_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready14 got %b want 1", io_in_ready); end
    tick();
    set_idle();
    n_run++; if (io_count !== 5'd14) begin n_fail++; $display("FAIL b2b_count14 got %0d want 14", io_count); end
    n_run++; if (io_out_pc[63:0] !== mq[0].pc) begin n_fail++; $display("FAIL b2b_head got %h want %h", io_out_pc[63:0], mq[0].pc); end
    clear();
  endtask

  // Random traffic long enough for both pointers to wrap several times
  task automatic test_wrap();
    int sent = 0;
    for (int cyc = 0; cyc < 400 && (sent < 40 || mq.size() != 0); cyc++) begin
      set_idle();
      if (sent < 40 && ($urandom_range(0, 3) != 0)) begin
        drive_pkt(2'($urandom_range(0, 3)), 64'({$urandom} & 32'hffff_fffc), $urandom, $urandom);
        io_in_bits_bp_valid  = 1'($urandom);
        io_in_bits_bp_select = 1'($urandom);
        io_in_bits_bp_taken  = 1'($urandom);
        io_in_bits_bp_target = {$urandom, $urandom};
        io_in_bits_bp_type   = 4'($urandom);
        if ((DEPTH - mq.size()) >= FW) sent++;
      end
      io_out_ready = (sent >= 40) ? 1'b1 : 1'($urandom);
      #1;
      for (int i = 0; i < DW; i++) begin
        logic ev;
        ev = (mq.size() > i);
        n_run++;
        if (io_out_valid[i] !== ev) begin
          n_fail++; $display("FAIL wrap_valid lane%0d cyc%0d got %b want %b", i, cyc, io_out_valid[i], ev);
        end else if (ev) begin
          n_run++;
          if (io_out_pc[i*64 +: 64] !== mq[i].pc || io_out_inst[i*32 +: 32] !== mq[i].inst ||
              io_out_bp_valid[i] !== mq[i].bpv || io_out_bp_taken[i] !== mq[i].tk ||
              io_out_bp_target[i*64 +: 64] !== mq[i].tgt || io_out_bp_type[i*4 +: 4] !== mq[i].typ) begin
            n_fail++;
            $display("FAIL wrap_lane%0d cyc%0d got pc=%h inst=%h want pc=%h inst=%h", i, cyc,
                     io_out_pc[i*64 +: 64], io_out_inst[i*32 +: 32], mq[i].pc, mq[i].inst);
          end
        end
      end
      n_run++;
      if (io_count !== 5'(mq.size())) begin
        n_fail++; $display("FAIL wrap_count cyc%0d got %0d want %0d", cyc, io_count, mq.size());
      end
      tick();
    end
    set_idle();
    n_run++; if (sent != 40 || mq.size() != 0) begin n_fail++; $display("FAIL wrap_done got sent=%0d left=%0d want 40/0", sent, mq.size()); end
  endtask

  task automatic test_flush();
    fill_to(9);
    drive_pkt(2'b11, 64'h7000, 32'h55, 32'h66);
    io_out_ready = 1'b1;
    io_i_flush   = 1'b1;
    #1;
    n_run++; if (io_out_valid !== 2'b00) begin n_fail++; $display("FAIL flush_out_valid got %b want 00", io_out_valid); end
    tick();
    set_idle();
    n_run++; if (io_count !== 5'd0 || io_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after got count=%0d ready=%b want 0/1", io_count, io_in_ready); end
    n_run++; if (io_out_valid !== 2'b00) begin n_fail++; $display("FAIL flush_dropped got %b want 00", io_out_valid); end
  endtask

  task automatic test_async_reset();
    fill_to(4);
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_run++; if (io_out_valid !== 2'b00 || io_count !== 5'd0) begin n_fail++; $display("FAIL areset got valid=%b count=%0d want 00/0", io_out_valid, io_count); end
    mq.delete();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_run++; if (io_in_ready !== 1'b1 || io_out_valid !== 2'b00) begin n_fail++; $display("FAIL areset_release got ready=%b valid=%b want 1/00", io_in_ready, io_out_valid); end
  endtask

  initial begin
    set_idle();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    test_basic();
    test_bp_attach();
    test_full();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
